// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: datapath width, the canonical NOP,
// fetch FSM encoding and the packed {pc, instr} queue entry.
package rv32i_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [0:0]  FS_BOOT   = 1'b0;
    localparam logic [0:0]  FS_RUN    = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch queue with flush. The head entry and its valid flag are
// registered so the decode-side outputs never see a combinational path.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  fetch_entry_t      push_data,
    input  logic              pop,
    output logic              head_valid,
    output fetch_entry_t      head_data,
    output logic [CW-1:0]     count
);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  head_q, head_d;
    logic          valid_q, valid_d;
    logic          do_push;
    logic          do_pop;
    fetch_entry_t  mem_view [DEPTH];

    assign do_push = push & ~flush & (count_q < CW'(DEPTH));
    assign do_pop  = pop  & ~flush & (count_q != '0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        fetch_entry_t entry_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                entry_q <= '0;
            end else if (do_push && (wr_ptr_q == PW'(gi))) begin
                entry_q <= push_data;
            end
        end

        assign mem_view[gi] = entry_q;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(do_pop);
            wr_ptr_d = wr_ptr_q + PW'(do_push);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
            // A push landing in the slot that becomes the head bypasses storage.
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_data;
            end else begin
                head_d = mem_view[rd_ptr_d];
            end
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign head_valid = valid_q;
    assign head_data  = head_q;
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch_rv32i.sv
// RV32I fetch unit: drives PC to a falling-edge ROM, captures INSTR on the
// next rising edge into a small queue, and hands entries to decode.
module instr_fetch_rv32i
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] PC,
    input  logic [31:0] INSTR,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [0:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          capture;
    logic          flush;
    logic          pop;
    logic [CW-1:0] count;
    fetch_entry_t  push_data;
    fetch_entry_t  head_data;
    logic          head_valid;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Capture looks only at the current count, never at out_ready.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = FS_RUN;
        end else if (state_q == FS_BOOT) begin
            state_d = FS_RUN;
        end else if (fetch_en && (count < CW'(DEPTH))) begin
            capture = 1'b1;
            pc_d    = pc_q + 32'd4;
        end
    end

    assign pop       = head_valid & out_ready & ~redirect_valid;
    assign push_data = '{pc: pc_q, instr: INSTR};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FS_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .push       (capture),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (count)
    );

    assign PC        = pc_q;
    assign out_valid = head_valid;
    assign out_pc    = head_data.pc;
    assign out_instr = head_data.instr;

endmodule

// File: doc/instr_fetch_rv32i.md
# instr_fetch_rv32i

RV32I instruction fetch unit: the initiator/reader on the instruction memory port. Drives a word-aligned byte address `PC` to the falling-edge instruction ROM, captures the returned `INSTR` at the next rising edge, and buffers `{pc, instr}` pairs in a 2-entry queue. The queue feeds the decode stage through a valid/ready handshake. Branch and jump redirects flush the queue.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0).
- `DEPTH`, 2, fetch queue entries (power of two, ≥2).

Ports:
- `clock`  in  1  single clock; rising-edge logic. The ROM samples on the falling edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `PC`  out  32  byte address to the instruction ROM; always word-aligned.
- `INSTR`  in  32  ROM data for `PC`; valid before the rising edge that ends the cycle.
- `fetch_en`  in  1  1 = fetching allowed; 0 = hold `PC`, no capture.
- `redirect_valid`  in  1  redirect request, sampled at the rising edge.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored.
- `out_valid`  out  1  queue head holds a valid instruction.
- `out_pc`  out  32  PC of the head instruction.
- `out_instr`  out  32  head instruction word.
- `out_ready`  in  1  decode accepts the head this cycle.

## Operation
- FSM has two states:
  - BOOT: entered on reset. No capture. Unconditionally moves to RUN after 1 cycle, so the ROM gets a full falling edge at `RESET_PC`.
  - RUN: normal operation.
- Capture condition (RUN only): `fetch_en & ~redirect_valid & (count < DEPTH)`. On capture:
  - push `{PC, INSTR}` at the queue tail;
  - `PC <= PC + 4`, 32-bit wrap (0xFFFF_FFFC → 0x0000_0000).
- Capture never depends combinationally on `out_ready`; there is no ready→PC path.
- Pop when `out_valid & out_ready`. Push and pop in the same cycle leave `count` unchanged.
- Redirect (`redirect_valid`=1 at an edge) has priority over everything, in either state:
  - `count <= 0`, head/tail pointers cleared;
  - `PC <= {redirect_pc[31:2], 2'b00}`;
  - no capture and no pop that cycle, even if `out_ready`=1;
  - state `<=` RUN.
- `fetch_en`=0: `PC` held; the queue still drains.
- Queue full (`count==DEPTH`): `PC` held and the current `INSTR` is discarded. The same address is re-read and re-captured once space frees.
- Queue empty: `out_valid`=0; `out_pc`/`out_instr` show stale head contents and are don't-care.
- Reset asserted mid-operation: all state clears immediately (async), and in-flight data is lost.

## Timing
- Reset values:
  - `PC`=`RESET_PC`, `out_valid`=0, `out_pc`=0, `out_instr`=0, `count`=0, state=BOOT;
  - all queue entries = 0.
- Latency:
  - address presented at edge k → instruction captured at edge k+1 → `out_valid`=1 after edge k+1;
  - first instruction after reset release appears 2 edges after the first edge with `reset_n`=1.
- Redirect at edge r: new `PC` presented after r; target instruction has `out_valid` after r+1.
- Throughput: 1 instruction/cycle sustained with `out_ready`=1 and `DEPTH`≥2.
- `out_*` are driven from registers; no combinational path from any input to any output.

## Structure
- Shared package `rv32i_pkg`:
  - `XLEN`=32;
  - `INSTR_NOP`=32'h0000_0013;
  - fetch state encoding (`FS_BOOT`, `FS_RUN`);
  - packed fetch-entry type `{pc[31:0], instr[31:0]}`.
- One sub-module, `fetch_fifo`: parameterised synchronous FIFO with push/pop/flush, registered head, and count. The top level holds the FSM, the PC register and the capture logic.

## Test plan
Bench uses a behavioural falling-edge ROM model in which word i = 32'hA000_0000 | i, addressed by `PC[6:2]`.
- Reset release, `fetch_en`=1, `out_ready`=1 → `out_valid` rises 2 edges after release with `out_pc`=0, `out_instr`=A000_0000. Then one instruction per cycle: pc 4,8,12… with instr …_0001, _0002, _0003.
- `out_ready`=0 for 5 cycles → `count` saturates at 2, `PC` holds at 0x08. Release → heads 0x00, 0x04, 0x08 in order, with no skip or duplicate.
- `redirect_valid`=1 with `redirect_pc`=0x0000_0043 while the queue is full → queue flushed, `PC`=0x40, no pop that cycle. Next `out_pc`=0x40 with `out_instr`=A000_0010.
- `fetch_en`=0 for 3 cycles mid-stream → `PC` constant and the queue drains to `out_valid`=0. Re-enable → fetch resumes at the held `PC`.
- Redirect to 0xFFFF_FFFC → `out_pc` sequence 0xFFFF_FFFC then 0x0000_0000 (wrap), with `out_instr` …_001F then …_0000.
- Assert `reset_n` low mid-cycle while streaming → `out_valid`=0 and `PC`=`RESET_PC` immediately, without waiting for a clock edge. After release, the first output is pc 0.
